cplx_mult_sched: RTL and testbench
==================================

Name: cplx_mult_sched

Overview:
- Round-robin scheduler that shares one complex-multiplier datapath between N_REQ requesters.
- Each requester presents packed complex operands with a valid/ready handshake. The scheduler grants one requester, forwards its operands downstream, waits for the result, and returns it to the same requester.
- Sits between client blocks and the complex multiplier's op/res handshake ports.
- Payloads pass through opaque; the scheduler does no arithmetic.

Parameters:
- DATA_WIDTH, 8, width of one real or imaginary component.
- N_REQ, 4, number of requesters (2..8).
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- sw_rst  in  1  synchronous reset, active high
- req_val  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester operand accepted; one-hot or zero
- req_data  in  N_REQ*4*DATA_WIDTH  requester i at slice i; each slice packed {a_re,a_im,b_re,b_im}
- rsp_val  out  N_REQ  per-requester result valid; one-hot or zero
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_data  out  4*DATA_WIDTH+3  shared result bus; meaningful only for the requester whose rsp_val bit is set
- mult_op_val  out  1  operand valid to multiplier
- mult_op_ready  in  1  multiplier ready for operands
- mult_op_data  out  4*DATA_WIDTH  operands to multiplier
- mult_res_val  in  1  multiplier result valid
- mult_res_ready  out  1  scheduler ready for result
- mult_res_data  in  4*DATA_WIDTH+3  multiplier result
- busy  out  1  high in any state other than IDLE
- ops_done  out  CNT_WIDTH  completed transactions, wraps at 2^CNT_WIDTH

Behaviour:
- Clock and reset: one clock, clk. Reset is sw_rst, synchronous and active high; no other reset exists.
- Reset values:
  - state = IDLE; rr_ptr = N_REQ-1, so requester 0 has top priority after reset.
  - op_reg, res_reg, owner = 0; ops_done = 0.
  - All outputs 0.
- State IDLE:
  - If any req_val is set, pick g = first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Assert req_ready[g] combinationally in this cycle only.
  - Register op_reg <= req_data slice g, owner <= g, rr_ptr <= g; go to SEND.
  - If no req_val is set, stay in IDLE.
- State SEND:
  - mult_op_val = 1, mult_op_data = op_reg; both held stable until accepted.
  - On mult_op_ready go to WAIT.
- State WAIT:
  - mult_res_ready = 1.
  - On mult_res_val: res_reg <= mult_res_data; go to RESP.
- State RESP:
  - rsp_val[owner] = 1, rsp_data = res_reg.
  - On rsp_ready[owner]: ops_done += 1; go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Outputs outside their state:
  - req_ready, mult_op_val, mult_res_ready and rsp_val are 0 outside their states.
  - rsp_data holds res_reg at all times.
- Latency and throughput:
  - Grant to mult_op_val: 1 cycle.
  - mult_res_val capture to rsp_val: 1 cycle.
  - With zero-wait downstream and consumer: minimum 4 cycles per transaction.
- Ordering: one transaction in flight at a time; results are always returned in order.
- Fairness: a requester that keeps req_val high is served within N_REQ transactions.
- Boundary conditions:
  - New req_val arriving in SEND/WAIT/RESP is not accepted until the next IDLE.
  - A requester may drop req_val before being granted without side effects.
  - mult_res_val seen outside WAIT is ignored; it is a protocol error, flagged by the bench assertion.
  - sw_rst in any state aborts the transaction: no rsp_val is issued, ops_done is not incremented, and the next cycle is IDLE with rr_ptr = N_REQ-1.
  - sw_rst has priority over every simultaneous handshake.
  - ops_done wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Package cplx_mult_sched_pkg:
  - State encoding localparams IDLE=2'd0, SEND=2'd1, WAIT=2'd2, RESP=2'd3.
  - OP_W = 4*DATA_WIDTH and RES_W = 4*DATA_WIDTH+3 width helpers.
- Sub-module cplx_mult_rr_arb: combinational rotating-priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.
- Top module holds the FSM, registers, counter and mux/demux.

Test Plan:
- Single request: req_val[0]=1 with req_data slice0=32'h03040506; bench multiplier returns {3'b0,16'hFFF7,16'h0026} 1 cycle after accept -> req_ready[0] pulses one cycle; mult_op_data=32'h03040506; rsp_val[0] with rsp_data=35'h0FFF70026; ops_done=1.
- Contention: all four req_val held high from reset for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each rsp_val on the owner bit only.
- Backpressure: mult_op_ready low 5 cycles, then rsp_ready[2] low 3 cycles -> mult_op_data and rsp_data stable throughout; exactly one ops_done increment.
- Skip idle requesters: req_val=4'b1010 after rr_ptr=1 -> grant 3, then 1; requesters 0 and 2 never see req_ready.
- Reset mid-op: assert sw_rst while in WAIT, then pulse mult_res_val -> no rsp_val; ops_done unchanged; busy=0; next grant goes to requester 0.
- Counter wrap: with CNT_WIDTH=4, run 17 transactions -> ops_done reads 1.

Source files
------------

// File: rtl/cplx_mult_sched_pkg.sv
// Shared types and width helpers for the complex-multiplier scheduler.
// Imported by the arbiter and the top-level scheduler.
package cplx_mult_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Packed operand width: {a_re, a_im, b_re, b_im}
    function automatic int op_w(input int dw);
        return 4 * dw;
    endfunction

    // Result width carried back from the multiplier
    function automatic int res_w(input int dw);
        return 4 * dw + 3;
    endfunction

    // Width of a requester index (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cplx_mult_rr_arb.sv
// Rotating-priority picker: the search starts just after the last
// winner, so every active requester is reached within N_REQ grants.
module cplx_mult_rr_arb
    import cplx_mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    rr_ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             any_o
);

    logic found;
    int   pos;

    // First set request scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            pos = (int'(rr_ptr_i) + i) % N_REQ;
            if (!found && req_i[pos]) begin
                found          = 1'b1;
                gnt_o[pos]     = 1'b1;
                gnt_idx_o      = IW'(pos);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/cplx_mult_sched.sv
// Shares one complex-multiplier datapath between N_REQ requesters,
// one transaction in flight; payloads pass through untouched.
module cplx_mult_sched
    import cplx_mult_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          sw_rst,
    input  logic [N_REQ-1:0]              req_val,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*4*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]              rsp_val,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [4*DATA_WIDTH+2:0]       rsp_data,
    output logic                          mult_op_val,
    input  logic                          mult_op_ready,
    output logic [4*DATA_WIDTH-1:0]       mult_op_data,
    input  logic                          mult_res_val,
    output logic                          mult_res_ready,
    input  logic [4*DATA_WIDTH+2:0]       mult_res_data,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          ops_done
);

    localparam int OP_W  = op_w(DATA_WIDTH);
    localparam int RES_W = res_w(DATA_WIDTH);
    localparam int IW    = idx_w(N_REQ);

    state_e               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        owner_q;
    logic [OP_W-1:0]      op_q;
    logic [OP_W-1:0]      op_d;
    logic [RES_W-1:0]     res_q;
    logic [CNT_WIDTH-1:0] ops_q;
    logic [CNT_WIDTH-1:0] ops_d;

    logic [N_REQ-1:0]     gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 any_req;
    logic [N_REQ-1:0]     owner_oh;

    cplx_mult_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req_i     (req_val),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    // Operand slice of the requester the arbiter is picking
    always_comb begin
        op_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                op_d = req_data[i*OP_W +: OP_W];
            end
        end
    end

    // Completed-transaction count, wraps naturally
    always_comb begin
        ops_d = ops_q + CNT_WIDTH'(1);
    end

    // FSM with operand/result/owner/pointer/counter registers
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(N_REQ - 1);
            owner_q  <= '0;
            op_q     <= '0;
            res_q    <= '0;
            ops_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        op_q     <= op_d;
                        owner_q  <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (mult_op_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mult_res_val) begin
                        res_q   <= mult_res_data;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        ops_q   <= ops_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One-hot decode of the transaction owner
    always_comb begin
        owner_oh = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Handshake outputs; reset masks them so it wins every handshake
    always_comb begin
        req_ready      = '0;
        mult_op_val    = 1'b0;
        mult_res_ready = 1'b0;
        rsp_val        = '0;
        if (!sw_rst) begin
            if (state_q == IDLE) req_ready = gnt;
            if (state_q == SEND) mult_op_val = 1'b1;
            if (state_q == WAIT) mult_res_ready = 1'b1;
            if (state_q == RESP) rsp_val = owner_oh;
        end
    end

    assign mult_op_data = op_q;
    assign rsp_data     = res_q;
    assign busy         = (state_q != IDLE);
    assign ops_done     = ops_q;

endmodule

// File: tb/tb_cplx_mult_sched.sv
// Self-checking bench for cplx_mult_sched: table vectors, corner
// sequences and randomized traffic against a behavioural model.
module tb_cplx_mult_sched;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              sw_rst;
    logic [N-1:0]      req_val;
    logic [N-1:0]      req_ready;
    logic [N*4*DW-1:0] req_data;
    logic [N-1:0]      rsp_val;
    logic [N-1:0]      rsp_ready;
    logic [4*DW+2:0]   rsp_data;
    logic              mult_op_val;
    logic              mult_op_ready;
    logic [4*DW-1:0]   mult_op_data;
    logic              mult_res_val;
    logic              mult_res_ready;
    logic [4*DW+2:0]   mult_res_data;
    logic              busy;
    logic [CW-1:0]     ops_done;

    cplx_mult_sched #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .sw_rst         (sw_rst),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .rsp_val        (rsp_val),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .mult_op_val    (mult_op_val),
        .mult_op_ready  (mult_op_ready),
        .mult_op_data   (mult_op_data),
        .mult_res_val   (mult_res_val),
        .mult_res_ready (mult_res_ready),
        .mult_res_data  (mult_res_data),
        .busy           (busy),
        .ops_done       (ops_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_ptr;
    int           m_ops;
    logic [31:0]  m_data [N];
    logic [31:0]  last_op;
    logic [34:0]  last_rsp;
    logic         stray_ok = 1'b0;

    typedef struct {
        logic [N-1:0] vals;
        int           opw;
        int           resl;
        int           rspw;
        int           exp_g;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // True complex product of signed components
    function automatic logic [34:0] cmul(input logic [31:0] d);
        int ar, ai, br, bi, re, im;
        logic [31:0] t;
        ar = int'($signed(d[31:24]));
        ai = int'($signed(d[23:16]));
        br = int'($signed(d[15:8]));
        bi = int'($signed(d[7:0]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        t  = {re[15:0], im[15:0]};
        return {3'b000, t};
    endfunction

    // Round-robin rule: first active requester after the last winner
    function automatic int pick(input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) req_data[i*32 +: 32] = m_data[i];
    endtask

    task automatic clr_hs();
        mult_op_ready = 1'b0;
        mult_res_val  = 1'b0;
        rsp_ready     = '0;
    endtask

    task automatic rst_dut();
        @(negedge clk);
        sw_rst  = 1'b1;
        req_val = '0;
        clr_hs();
        @(negedge clk);
        sw_rst = 1'b0;
        m_ptr  = N - 1;
        m_ops  = 0;
    endtask

    // Multiplier model: flags results offered when nobody is listening
    always @(posedge clk) begin
        if (mult_res_val && !mult_res_ready && !stray_ok) begin
            errors++;
            $display("FAIL res_protocol actual=ready0 expected=ready1");
        end
    end

    task automatic do_txn(input logic [N-1:0] vals, input int opw,
                          input int resl, input int rspw,
                          input int exp_g);
        int          eg;
        logic [31:0] expd;
        logic [34:0] mres;
        logic [N-1:0] oh;
        @(negedge clk);
        clr_hs();
        req_val = vals;
        drive_data();
        #1;
        eg = (exp_g >= 0) ? exp_g : pick(vals);
        oh = '0;
        oh[eg] = 1'b1;
        check("grant", 64'(req_ready), 64'(oh));
        check("idle_busy", 64'(busy), 64'd0);
        m_ptr = eg;
        expd  = m_data[eg];
        mres  = '0;
        for (int k = 0; k <= opw; k++) begin
            @(negedge clk);
            clr_hs();
            if (k == 0) begin
                for (int i = 0; i < N; i++) m_data[i] = $urandom;
                drive_data();
            end
            if (k == opw) mult_op_ready = 1'b1;
            #1;
            check("op_val", 64'(mult_op_val), 64'd1);
            check("op_data", 64'(mult_op_data), 64'(expd));
            check("no_regrant", 64'(req_ready), 64'd0);
            mres    = cmul(mult_op_data);
            last_op = mult_op_data;
        end
        for (int k = 0; k <= resl; k++) begin
            @(negedge clk);
            clr_hs();
            mult_res_data = {3'b111, $urandom};
            if (k == resl) begin
                mult_res_val  = 1'b1;
                mult_res_data = mres;
            end
            #1;
            check("res_ready", 64'(mult_res_ready), 64'd1);
            check("rsp_quiet", 64'(rsp_val), 64'd0);
        end
        for (int k = 0; k <= rspw; k++) begin
            @(negedge clk);
            clr_hs();
            mult_res_data = {3'b101, $urandom};
            rsp_ready = ~oh;
            if (k == rspw) rsp_ready = rsp_ready | oh;
            #1;
            check("rsp_val", 64'(rsp_val), 64'(oh));
            check("rsp_data", 64'(rsp_data), 64'(cmul(expd)));
            last_rsp = rsp_data;
        end
        m_ops = (m_ops + 1) % (1 << CW);
        @(negedge clk);
        clr_hs();
        req_val = '0;
        #1;
        check("ops_done", 64'(ops_done), 64'(m_ops));
        check("done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 0, 0, 0, i % 4};
        tbl[8]  = '{4'b0100, 5, 1, 3, 2};
        tbl[9]  = '{4'b0010, 0, 2, 0, 1};
        tbl[10] = '{4'b1010, 1, 0, 2, 3};
        tbl[11] = '{4'b1010, 0, 0, 0, 1};
        tbl[12] = '{4'b0001, 2, 3, 1, 0};

        sw_rst        = 1'b1;
        req_val       = '0;
        req_data      = '0;
        mult_res_data = '0;
        clr_hs();
        for (int i = 0; i < N; i++) m_data[i] = $urandom;
        rst_dut();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_op_val", 64'(mult_op_val), 64'd0);
        check("rst_res_ready", 64'(mult_res_ready), 64'd0);
        check("rst_rsp_val", 64'(rsp_val), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_op_data", 64'(mult_op_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ops", 64'(ops_done), 64'd0);

        // Single request with a known product
        m_data[0] = 32'h03040506;
        do_txn(4'b0001, 0, 0, 0, 0);
        check("single_op", 64'(last_op), 64'h03040506);
        check("single_rsp", 64'(last_rsp), 64'h0FFF70026);
        check("single_ops", 64'(ops_done), 64'd1);

        // Contention, backpressure and idle-requester skipping
        rst_dut();
        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i].vals, tbl[i].opw, tbl[i].resl,
                   tbl[i].rspw, tbl[i].exp_g);
        end

        // Reset while waiting for a result, then a stray result
        rst_dut();
        @(negedge clk);
        req_val = 4'b0100;
        drive_data();
        #1;
        check("mid_grant", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_val       = '0;
        mult_op_ready = 1'b1;
        @(negedge clk);
        clr_hs();
        #1;
        check("mid_wait", 64'(mult_res_ready), 64'd1);
        sw_rst  = 1'b1;
        req_val = 4'hF;
        #1;
        check("mid_rst_ready", 64'(mult_res_ready), 64'd0);
        check("mid_rst_grant", 64'(req_ready), 64'd0);
        @(negedge clk);
        sw_rst        = 1'b0;
        req_val       = '0;
        stray_ok      = 1'b1;
        mult_res_val  = 1'b1;
        mult_res_data = 35'h5A5A5A5A5;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_rsp", 64'(rsp_val), 64'd0);
        check("mid_ops", 64'(ops_done), 64'd0);
        @(negedge clk);
        clr_hs();
        #1;
        stray_ok = 1'b0;
        check("stray_rsp", 64'(rsp_val), 64'd0);
        check("stray_data", 64'(rsp_data), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);
        m_ptr = N - 1;
        m_ops = 0;
        do_txn(4'hF, 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) m_data[i] = $urandom;
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        // Counter wrap on a 4-bit counter
        rst_dut();
        for (int t = 0; t < 17; t++) begin
            do_txn(4'($urandom_range(1, 15)), 0, 0, 0, -1);
        end
        check("ops_wrap", 64'(ops_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
